// File: rtl/count_stream_if.sv
// Count stream bus: sampled counter value plus its valid strobe.
interface count_stream_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] in_count;

    modport master (output in_valid, output in_count);
    modport slave  (input  in_valid, input  in_count);
endinterface

// File: rtl/count_stream_decoder.sv
// Recovers parity/direction from an observed count stream,
// flags illegal steps and reports lock after a run of legal steps.
module count_stream_decoder #(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 4,
    parameter int ERR_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    count_stream_if.slave      s_in,
    output logic               p_out,
    output logic               f_out,
    output logic               step_pulse,
    output logic               align_pulse,
    output logic               err_pulse,
    output logic               lock,
    output logic [ERR_W-1:0]   err_count
);
    typedef enum logic [1:0] {EMPTY, ACQ, LOCKED} state_t;

    localparam logic [WIDTH-1:0] D_ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] D_TWO   = WIDTH'(2);
    localparam logic [WIDTH-1:0] D_BACK  = ~D_ONE;
    localparam logic [3:0]       RUN_MAX = 4'(LOCK_COUNT);

    state_t           r_state, w_state_n;
    logic [WIDTH-1:0] r_prev, w_prev_n, w_d;
    logic [3:0]       r_run, w_run_n;
    logic             r_p, w_p_n, r_f, w_f_n;
    logic             r_step, w_step_n, r_align, w_align_n;
    logic             r_err, w_err_n, r_lock, w_lock_n;
    logic [ERR_W-1:0] r_errc, w_errc_n;
    logic             w_legal;

    assign w_d     = s_in.in_count - r_prev;
    assign w_legal = (w_d == D_ONE) || (w_d == D_TWO) || (w_d == D_BACK);

    always_comb begin
        w_state_n = r_state;
        w_prev_n  = r_prev;
        w_run_n   = r_run;
        w_p_n     = r_p;
        w_f_n     = r_f;
        w_lock_n  = r_lock;
        w_errc_n  = r_errc;
        w_step_n  = 1'b0;
        w_align_n = 1'b0;
        w_err_n   = 1'b0;
        if (clr) begin
            // Clear wins over a coincident sample, which is dropped
            w_state_n = EMPTY;
            w_run_n   = '0;
            w_lock_n  = 1'b0;
            w_errc_n  = '0;
            w_p_n     = 1'b0;
            w_f_n     = 1'b0;
        end else if (s_in.in_valid) begin
            w_prev_n = s_in.in_count;
            if (r_state == EMPTY) begin
                w_state_n = ACQ;
            end else if (w_legal) begin
                w_p_n = s_in.in_count[0];
                unique case (1'b1)
                    (w_d == D_ONE):  w_align_n = 1'b1;
                    (w_d == D_TWO):  begin w_f_n = 1'b1; w_step_n = 1'b1; end
                    (w_d == D_BACK): begin w_f_n = 1'b0; w_step_n = 1'b1; end
                endcase
                w_run_n = (r_run >= RUN_MAX) ? RUN_MAX : r_run + 4'd1;
                if (w_run_n == RUN_MAX) begin
                    w_state_n = LOCKED;
                    w_lock_n  = 1'b1;
                end
            end else begin
                w_err_n   = 1'b1;
                w_errc_n  = (&r_errc) ? r_errc : r_errc + 1'b1;
                w_run_n   = '0;
                w_state_n = ACQ;
                w_lock_n  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
            r_prev  <= '0;
            r_run   <= '0;
            r_p     <= 1'b0;
            r_f     <= 1'b0;
            r_step  <= 1'b0;
            r_align <= 1'b0;
            r_err   <= 1'b0;
            r_lock  <= 1'b0;
            r_errc  <= '0;
        end else begin
            r_state <= w_state_n;
            r_prev  <= w_prev_n;
            r_run   <= w_run_n;
            r_p     <= w_p_n;
            r_f     <= w_f_n;
            r_step  <= w_step_n;
            r_align <= w_align_n;
            r_err   <= w_err_n;
            r_lock  <= w_lock_n;
            r_errc  <= w_errc_n;
        end
    end

    assign p_out       = r_p;
    assign f_out       = r_f;
    assign step_pulse  = r_step;
    assign align_pulse = r_align;
    assign err_pulse   = r_err;
    assign lock        = r_lock;
    assign err_count   = r_errc;
endmodule

// File: tb/tb_count_stream_decoder.sv
// Directed vector bench for count_stream_decoder.
module tb_count_stream_decoder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       p_out, f_out, step_pulse, align_pulse, err_pulse, lock;
    logic [7:0] err_count;
    int         n_cmp = 0;
    int         n_bad = 0;

    count_stream_if #(.WIDTH(4)) bus ();

    count_stream_decoder #(.WIDTH(4), .LOCK_COUNT(4), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .clr(clr), .s_in(bus),
        .p_out(p_out), .f_out(f_out), .step_pulse(step_pulse),
        .align_pulse(align_pulse), .err_pulse(err_pulse),
        .lock(lock), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        c;
        logic        v;
        logic [3:0]  cnt;
        logic [13:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic c, logic v, int cnt, logic p, logic f,
                                logic s, logic a, logic e, logic l, int ec);
        vec_t r;
        r.c   = c;
        r.v   = v;
        r.cnt = 4'(cnt);
        r.exp = {p, f, s, a, e, l, 8'(ec)};
        return r;
    endfunction

    function automatic logic [13:0] outs();
        return {p_out, f_out, step_pulse, align_pulse, err_pulse, lock, err_count};
    endfunction

    task automatic check(string name, logic [13:0] got, logic [13:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got pfsael/cnt=%b/%0d expected %b/%0d",
                     name, got[13:8], got[7:0], exp[13:8], exp[7:0]);
        end
    endtask

    task automatic drive(logic c, logic v, int cnt);
        @(negedge clk);
        clr          = c;
        bus.in_valid = v;
        bus.in_count = 4'(cnt);
        @(posedge clk);
        #1;
    endtask

    int last;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_count = '0;
        // test 1: lock-up
        tbl.push_back(mk(0,1, 0, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1, 1, 1,0,0,1,0,0,0));
        tbl.push_back(mk(0,1, 3, 1,1,1,0,0,0,0));
        tbl.push_back(mk(0,1, 5, 1,1,1,0,0,0,0));
        tbl.push_back(mk(0,1, 7, 1,1,1,0,0,1,0));
        // test 2: wrap
        tbl.push_back(mk(1,0, 0, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,13, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,15, 1,1,1,0,0,0,0));
        tbl.push_back(mk(0,1, 1, 1,1,1,0,0,0,0));
        tbl.push_back(mk(0,1, 3, 1,1,1,0,0,0,0));
        tbl.push_back(mk(0,1,15, 1,1,0,0,1,0,1));
        tbl.push_back(mk(0,1, 0, 0,1,0,1,0,0,1));
        tbl.push_back(mk(0,1,14, 0,0,1,0,0,0,1));
        tbl.push_back(mk(0,1,12, 0,0,1,0,0,0,1));
        // test 3: illegal step and relock
        tbl.push_back(mk(1,0, 0, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1, 4, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1, 6, 0,1,1,0,0,0,0));
        tbl.push_back(mk(0,1, 8, 0,1,1,0,0,0,0));
        tbl.push_back(mk(0,1,10, 0,1,1,0,0,0,0));
        tbl.push_back(mk(0,1,12, 0,1,1,0,0,1,0));
        tbl.push_back(mk(0,1,15, 0,1,0,0,1,0,1));
        tbl.push_back(mk(0,1, 1, 1,1,1,0,0,0,1));
        tbl.push_back(mk(0,1, 3, 1,1,1,0,0,0,1));
        tbl.push_back(mk(0,1, 5, 1,1,1,0,0,0,1));
        tbl.push_back(mk(0,1, 7, 1,1,1,0,0,1,1));
        tbl.push_back(mk(0,0, 9, 1,1,0,0,0,1,1));
        // test 4: gaps
        tbl.push_back(mk(1,0, 0, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1, 2, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0, 7, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0, 3, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0, 9, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1, 4, 0,1,1,0,0,0,0));
        // test 5: clr beats valid
        tbl.push_back(mk(0,1, 9, 0,1,0,0,1,0,1));
        tbl.push_back(mk(0,1, 9, 0,1,0,0,1,0,2));
        tbl.push_back(mk(0,1, 9, 0,1,0,0,1,0,3));
        tbl.push_back(mk(0,1,11, 1,1,1,0,0,0,3));
        tbl.push_back(mk(0,1,13, 1,1,1,0,0,0,3));
        tbl.push_back(mk(0,1,15, 1,1,1,0,0,0,3));
        tbl.push_back(mk(0,1, 1, 1,1,1,0,0,1,3));
        tbl.push_back(mk(1,1, 9, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1, 9, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,11, 1,1,1,0,0,0,0));

        repeat (2) @(posedge clk);
        #1;
        check("reset", outs(), 14'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].c, tbl[i].v, tbl[i].cnt);
            check($sformatf("vec%0d", i), outs(), tbl[i].exp);
        end

        // test 6: saturation
        drive(1, 0, 0);
        drive(0, 1, 0);
        for (int i = 0; i < 300; i++) begin
            last = (i % 2 == 0) ? 5 : 0;
            drive(0, 1, last);
            if (i == 254)
                check("sat255", outs(), {6'b000010, 8'd255});
            if (i == 299)
                check("sat_hold", outs(), {6'b000010, 8'd255});
        end
        drive(0, 1, 2);
        drive(0, 1, 4);
        drive(0, 1, 6);
        drive(0, 1, 8);
        check("relock_sat", outs(), {6'b011001, 8'd255});

        // asynchronous reset while clk is high
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", outs(), 14'd0);
        @(negedge clk);
        check("rst_hold", outs(), 14'd0);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/count_stream_decoder.md
Name: count_stream_decoder

Overview:
- Receive-side decoder for the 4-bit parity/direction count stream produced by the team's counter generator.
- The generator does two things:
  - On a parity mismatch it steps +1 to align to odd (P=1) or even (P=0).
  - Otherwise it steps +2 (F=1) or -2 (F=0), modulo 16.
- This block observes sampled count values, recovers P and F, flags illegal steps and reports lock.
- It sits at the consumer end of the count interface.

Parameters:
- WIDTH, 4, count width; all step arithmetic is modulo 2^WIDTH.
- LOCK_COUNT, 4, consecutive legal steps needed to assert lock (range 1..15).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear; returns the block to EMPTY and zeroes err_count.
- in_valid  input  1  in_count is sampled on this cycle.
- in_count  input  WIDTH  observed counter value.
- p_out  output  1  last decoded parity (1 = odd target).
- f_out  output  1  last decoded direction (1 = forward/+2).
- step_pulse  output  1  one-cycle pulse: a ±2 step was decoded.
- align_pulse  output  1  one-cycle pulse: a +1 alignment step was decoded.
- err_pulse  output  1  one-cycle pulse: an illegal step was seen.
- lock  output  1  level; LOCK_COUNT consecutive legal steps seen since the last error, clear or reset.
- err_count  output  ERR_W  saturating count of illegal steps.

Behaviour:
- All outputs are registered. Each reflects the in_valid sample from the previous cycle, i.e. latency 1.
- Reset value of every output is 0. Internal prev register, run counter and state also reset to 0 / EMPTY.
- Reset applies immediately and asynchronously, including mid-lock.
- States and transitions:
  - EMPTY: no previous sample. On in_valid, store prev=in_count, go to ACQ. No pulses.
  - ACQ: tracking, not locked. Each legal step increments run. When run reaches LOCK_COUNT, go to LOCKED and assert lock.
  - LOCKED: an illegal step deasserts lock, clears run and returns to ACQ.
  - An illegal step in ACQ also clears run.
- Step classification for each in_valid sample in ACQ/LOCKED:
  - Compute d = (in_count - prev) mod 2^WIDTH.
  - d==1: alignment. p_out<=in_count[0]; f_out unchanged; align_pulse=1; legal.
  - d==2: p_out<=in_count[0]; f_out<=1; step_pulse=1; legal.
  - d==2^WIDTH-2: p_out<=in_count[0]; f_out<=0; step_pulse=1; legal.
  - Any other d, including 0: err_pulse=1; err_count+1, saturating at all-ones; p_out/f_out unchanged; illegal.
  - prev<=in_count on every valid sample, legal or not. The next step is judged from the new value.
- Wrap-around:
  - 15→1 is d=2 (forward).
  - 0→14 is d=14 (backward).
  - 15→0 is d=1 (alignment to even).
- Run counter saturates at LOCK_COUNT.
- in_valid low: no state change; pulses low; levels hold.
- clr has priority over in_valid on the same cycle:
  - The sample is discarded.
  - State goes to EMPTY; run, lock and err_count go to 0.
  - p_out and f_out are cleared; pulses are low.
- At most one of step_pulse, align_pulse and err_pulse is high in any cycle.

Test Plan:
1. Lock-up:
   - Stimulus: rst pulse, then in_valid=1 with samples 0,1,3,5,7 on consecutive cycles.
   - Response: align_pulse after sample 1 with p_out=1; step_pulse with f_out=1 after 3, 5 and 7; lock=1 in the cycle after 7 is sampled; err_count=0.
2. Wrap:
   - Stimulus: samples 13,15,1,3.
   - Response: f_out=1, p_out=1, no err.
   - Stimulus: then samples 15,0,14,12.
   - Response: err_pulse for 3→15 (d=12); align_pulse for 15→0 with p_out=0; then f_out=0 for 0→14 and 14→12.
3. Illegal step:
   - Stimulus: locked on 4,6,8,10,12, then 15.
   - Response: err_pulse=1, err_count=1, lock=0, p_out/f_out unchanged.
   - Stimulus: then 1,3,5,7.
   - Response: relock after the 4th legal step.
4. Gaps:
   - Stimulus: samples 2,4 with in_valid low for 3 cycles between them.
   - Response: one step_pulse, f_out=1; no pulses during the gap.
5. clr vs valid:
   - Stimulus: locked, err_count=3; assert clr and in_valid together with in_count=9.
   - Response: next cycle lock=0, err_count=0, state EMPTY.
   - Stimulus: then samples 9,11.
   - Response: step_pulse only after 11.
6. Reset and saturation:
   - Stimulus: 300 illegal steps (alternating 0,5).
   - Response: err_count holds at 255.
   - Stimulus: assert rst mid-cycle.
   - Response: all outputs 0 immediately, without waiting for a clk edge.
